// File: rtl/dsp_slice_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_slice_pkg
//  Brief    : Shared encodings, width derivation and saturation helpers
//             for the parametrised DSP slice.
//  Revision : 1.0  initial release
// ============================================================================
package dsp_slice_pkg;

  localparam logic [1:0] FUNC_MUL    = 2'b00;
  localparam logic [1:0] FUNC_MULADD = 2'b01;
  localparam logic [1:0] FUNC_PREADD = 2'b10;
  localparam logic [1:0] FUNC_DOT    = 2'b11;

  function automatic int calc_rwidth(input int dwidth, input int guard);
    return 2 * dwidth + guard;
  endfunction

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

  function automatic logic fits(input logic signed [63:0] v, input int w);
    return (v == sat_clamp(v, w));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_slice_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_slice_param_if
//  Brief    : Operand, control, scan, cascade and result bundle of the slice.
//  Revision : 1.0  initial release
// ============================================================================
interface dsp_slice_param_if
  import dsp_slice_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int LANES  = 2,
  parameter int GUARD  = 4
) ();
  localparam int RWIDTH = calc_rwidth(DWIDTH, GUARD);

  logic                      enable;
  logic                      in_valid;
  logic [1:0]                func;
  logic                      loadconst;
  logic                      accumulate;
  logic                      negate;
  logic                      sub;
  logic                      scan_en;
  logic [LANES*DWIDTH-1:0]   y;
  logic [LANES*DWIDTH-1:0]   z;
  logic [LANES*DWIDTH-1:0]   x;
  logic [LANES*RWIDTH-1:0]   constant;
  logic [DWIDTH-1:0]         scanin;
  logic [DWIDTH-1:0]         scanout;
  logic [RWIDTH-1:0]         chainin;
  logic [RWIDTH-1:0]         chainout;
  logic [LANES*RWIDTH-1:0]   result;
  logic                      out_valid;
  logic [LANES-1:0]          ovf;

  modport master (
    output enable, in_valid, func, loadconst, accumulate, negate, sub, scan_en,
    output y, z, x, constant, scanin, chainin,
    input  scanout, chainout, result, out_valid, ovf
  );

  modport slave (
    input  enable, in_valid, func, loadconst, accumulate, negate, sub, scan_en,
    input  y, z, x, constant, scanin, chainin,
    output scanout, chainout, result, out_valid, ovf
  );
endinterface
`default_nettype wire

// File: rtl/dsp_mac_lane.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_mac_lane
//  Brief    : One MAC lane: S2 term formation and S3 accumulate/saturate.
//  Revision : 1.0  initial release
// ============================================================================
module dsp_mac_lane
  import dsp_slice_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int RWIDTH = 20,
  parameter int SAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  input  logic signed [DWIDTH-1:0] i_y,
  input  logic signed [DWIDTH-1:0] i_z,
  input  logic signed [DWIDTH-1:0] i_x,
  input  logic [1:0]               i_func,
  input  logic                     i_negate,
  input  logic                     i_valid,
  input  logic                     i_loadconst,
  input  logic                     i_accumulate,
  input  logic signed [RWIDTH-1:0] i_const,
  input  logic signed [RWIDTH:0]   i_addend,
  output logic signed [RWIDTH-1:0] o_prod,
  output logic signed [RWIDTH-1:0] o_acc,
  output logic                     o_ovf
);
  localparam int EXT = RWIDTH - DWIDTH;
  localparam int SW  = RWIDTH + 2;

  logic signed [RWIDTH-1:0] w_y, w_z, w_x, w_prod, w_raw, w_term, w_base, w_next;
  logic signed [SW-1:0]     w_sum;
  logic signed [63:0]       w_sum64, w_clamped;
  logic                     w_fits;
  logic signed [RWIDTH-1:0] r_t, r_acc;
  logic                     r_ovf;

  assign w_y    = {{EXT{i_y[DWIDTH-1]}}, i_y};
  assign w_z    = {{EXT{i_z[DWIDTH-1]}}, i_z};
  assign w_x    = {{EXT{i_x[DWIDTH-1]}}, i_x};
  assign w_prod = w_y * w_z;
  assign o_prod = w_prod;

  always_comb begin
    w_raw = w_prod;
    case (i_func)
      FUNC_MULADD: w_raw = w_prod + w_x;
      FUNC_PREADD: w_raw = (w_y + w_x) * w_z;
      default:     w_raw = w_prod;
    endcase
  end

  assign w_term = i_negate ? -w_raw : w_raw;

  always_ff @(posedge clk) begin
    if (rst)       r_t <= '0;
    else if (i_en) r_t <= w_term;
  end

  always_comb begin
    w_base = '0;
    if (i_loadconst)       w_base = i_const;
    else if (i_accumulate) w_base = r_acc;
  end

  // Two headroom bits keep base + term + addend exact before clamping.
  assign w_sum     = {{2{w_base[RWIDTH-1]}}, w_base} + {{2{r_t[RWIDTH-1]}}, r_t}
                   + {i_addend[RWIDTH], i_addend};
  assign w_sum64   = {{(64-SW){w_sum[SW-1]}}, w_sum};
  assign w_clamped = sat_clamp(w_sum64, RWIDTH);
  assign w_fits    = fits(w_sum64, RWIDTH);
  assign w_next    = (SAT != 0) ? RWIDTH'(w_clamped) : w_sum[RWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (i_en && i_valid) begin
      r_acc <= w_next;
      if (!w_fits) r_ovf <= 1'b1;
    end
  end

  assign o_acc = r_acc;
  assign o_ovf = r_ovf;
endmodule
`default_nettype wire

// File: rtl/dsp_slice_param.sv
`default_nettype none
// ============================================================================
//  Module   : dsp_slice_param
//  Brief    : LANES-wide pipelined signed MAC slice with pre-adder, dot mode,
//             scan chain through S1 y-registers and a lane-0 cascade input.
//  Revision : 1.0  initial release
// ============================================================================
module dsp_slice_param
  import dsp_slice_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int LANES  = 2,
  parameter int GUARD  = 4,
  parameter int SAT    = 1
) (
  input  logic             clk,
  input  logic             clr,
  dsp_slice_param_if.slave bus
);
  localparam int RWIDTH = calc_rwidth(DWIDTH, GUARD);

  logic signed [DWIDTH-1:0] r_s1_y [LANES];
  logic signed [DWIDTH-1:0] r_s1_z [LANES];
  logic signed [DWIDTH-1:0] r_s1_x [LANES];
  logic [1:0]               r_s1_func;
  logic                     r_s1_negate, r_s1_loadconst, r_s1_accumulate, r_s1_sub;
  logic                     r_s1_valid;

  logic                     r_s2_valid, r_s2_loadconst, r_s2_accumulate, r_s2_sub;
  logic signed [RWIDTH-1:0] r_s2_dot;
  logic                     r_out_valid;

  logic signed [RWIDTH-1:0] w_prod [LANES];
  logic signed [RWIDTH-1:0] w_acc  [LANES];
  logic [LANES-1:0]         w_ovf;
  logic signed [RWIDTH-1:0] w_dot_sum;
  logic signed [RWIDTH:0]   w_chain_in, w_chain, w_addend0;
  logic [LANES*RWIDTH-1:0]  w_result;

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LANES; i++) begin
        r_s1_y[i] <= '0;
        r_s1_z[i] <= '0;
        r_s1_x[i] <= '0;
      end
      r_s1_func       <= FUNC_MUL;
      r_s1_negate     <= 1'b0;
      r_s1_loadconst  <= 1'b0;
      r_s1_accumulate <= 1'b0;
      r_s1_sub        <= 1'b0;
      r_s1_valid      <= 1'b0;
    end else if (bus.enable) begin
      if (bus.scan_en) begin
        r_s1_y[0] <= bus.scanin;
        for (int i = 1; i < LANES; i++) r_s1_y[i] <= r_s1_y[i-1];
        r_s1_valid <= 1'b0;
      end else begin
        for (int i = 0; i < LANES; i++) begin
          r_s1_y[i] <= bus.y[i*DWIDTH +: DWIDTH];
          r_s1_z[i] <= bus.z[i*DWIDTH +: DWIDTH];
          r_s1_x[i] <= bus.x[i*DWIDTH +: DWIDTH];
        end
        r_s1_func       <= bus.func;
        r_s1_negate     <= bus.negate;
        r_s1_loadconst  <= bus.loadconst;
        r_s1_accumulate <= bus.accumulate;
        r_s1_sub        <= bus.sub;
        r_s1_valid      <= bus.in_valid;
      end
    end
  end

  assign bus.scanout = r_s1_y[LANES-1];

  // Lane 0 already holds its own product; the dot term adds the other lanes.
  always_comb begin
    w_dot_sum = '0;
    for (int i = 1; i < LANES; i++) w_dot_sum = w_dot_sum + w_prod[i];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_s2_valid      <= 1'b0;
      r_s2_loadconst  <= 1'b0;
      r_s2_accumulate <= 1'b0;
      r_s2_sub        <= 1'b0;
      r_s2_dot        <= '0;
      r_out_valid     <= 1'b0;
    end else begin
      r_out_valid <= bus.enable & r_s2_valid;
      if (bus.enable) begin
        r_s2_valid      <= r_s1_valid;
        r_s2_loadconst  <= r_s1_loadconst;
        r_s2_accumulate <= r_s1_accumulate;
        r_s2_sub        <= r_s1_sub;
        r_s2_dot        <= (r_s1_func == FUNC_DOT)
                           ? (r_s1_negate ? -w_dot_sum : w_dot_sum) : '0;
      end
    end
  end

  assign w_chain_in = {bus.chainin[RWIDTH-1], bus.chainin};
  assign w_chain    = r_s2_sub ? -w_chain_in : w_chain_in;
  assign w_addend0  = {r_s2_dot[RWIDTH-1], r_s2_dot} + w_chain;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [RWIDTH:0] w_addend;
    assign w_addend = (i == 0) ? w_addend0 : '0;

    dsp_mac_lane #(
      .DWIDTH (DWIDTH),
      .RWIDTH (RWIDTH),
      .SAT    (SAT)
    ) u_lane (
      .clk          (clk),
      .rst          (clr),
      .i_en         (bus.enable),
      .i_y          (r_s1_y[i]),
      .i_z          (r_s1_z[i]),
      .i_x          (r_s1_x[i]),
      .i_func       (r_s1_func),
      .i_negate     (r_s1_negate),
      .i_valid      (r_s2_valid),
      .i_loadconst  (r_s2_loadconst),
      .i_accumulate (r_s2_accumulate),
      .i_const      (bus.constant[i*RWIDTH +: RWIDTH]),
      .i_addend     (w_addend),
      .o_prod       (w_prod[i]),
      .o_acc        (w_acc[i]),
      .o_ovf        (w_ovf[i])
    );
  end

  always_comb begin
    w_result = '0;
    for (int i = 0; i < LANES; i++) w_result[i*RWIDTH +: RWIDTH] = w_acc[i];
  end

  assign bus.result    = w_result;
  assign bus.chainout  = w_acc[LANES-1];
  assign bus.ovf       = w_ovf;
  assign bus.out_valid = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_dsp_slice_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dsp_slice_param
//  Brief    : Directed self-checking bench; a saturating and a wrapping slice
//             share one stimulus stream.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dsp_slice_param;
  localparam int DW = 8;
  localparam int LN = 2;
  localparam int GD = 4;
  localparam int RW = 2*DW + GD;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dsp_slice_param_if #(.DWIDTH(DW), .LANES(LN), .GUARD(GD)) if_s ();
  dsp_slice_param_if #(.DWIDTH(DW), .LANES(LN), .GUARD(GD)) if_w ();

  assign if_w.enable     = if_s.enable;
  assign if_w.in_valid   = if_s.in_valid;
  assign if_w.func       = if_s.func;
  assign if_w.loadconst  = if_s.loadconst;
  assign if_w.accumulate = if_s.accumulate;
  assign if_w.negate     = if_s.negate;
  assign if_w.sub        = if_s.sub;
  assign if_w.scan_en    = if_s.scan_en;
  assign if_w.y          = if_s.y;
  assign if_w.z          = if_s.z;
  assign if_w.x          = if_s.x;
  assign if_w.constant   = if_s.constant;
  assign if_w.scanin     = if_s.scanin;
  assign if_w.chainin    = if_s.chainin;

  dsp_slice_param #(.DWIDTH(DW), .LANES(LN), .GUARD(GD), .SAT(1)) u_dut_sat (
    .clk (clk), .clr (clr), .bus (if_s)
  );
  dsp_slice_param #(.DWIDTH(DW), .LANES(LN), .GUARD(GD), .SAT(0)) u_dut_wrap (
    .clk (clk), .clr (clr), .bus (if_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] res_s(input int lane);
    logic signed [RW-1:0] t;
    t = if_s.result[lane*RW +: RW];
    return {{(64-RW){t[RW-1]}}, t};
  endfunction

  function automatic logic signed [63:0] res_w(input int lane);
    logic signed [RW-1:0] t;
    t = if_w.result[lane*RW +: RW];
    return {{(64-RW){t[RW-1]}}, t};
  endfunction

  task automatic set_ops(input int ay, input int az, input int ax,
                         input int by, input int bz, input int bx);
    if_s.y = {DW'(by), DW'(ay)};
    if_s.z = {DW'(bz), DW'(az)};
    if_s.x = {DW'(bx), DW'(ax)};
  endtask

  task automatic one_beat();
    if_s.in_valid = 1'b1;
    tick();
    if_s.in_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b1;
    if_s.enable = 1'b1; if_s.in_valid = 1'b0; if_s.func = 2'b00;
    if_s.loadconst = 1'b0; if_s.accumulate = 1'b0; if_s.negate = 1'b0;
    if_s.sub = 1'b0; if_s.scan_en = 1'b0;
    if_s.y = '0; if_s.z = '0; if_s.x = '0; if_s.constant = '0;
    if_s.scanin = '0; if_s.chainin = '0;
    tick();
    tick();
    clr = 1'b0;

    // Reset state
    chk("rst_result",   {{(64-LN*RW){1'b0}}, if_s.result}, 64'sd0);
    chk("rst_outvalid", {63'd0, if_s.out_valid}, 64'sd0);
    chk("rst_ovf",      {62'd0, if_s.ovf}, 64'sd0);
    chk("rst_scanout",  {56'd0, if_s.scanout}, 64'sd0);
    chk("rst_chainout", {44'd0, if_s.chainout}, 64'sd0);

    // 1: plain multiply, 3-cycle latency, single out_valid pulse
    set_ops(1, 2, 0, 4, 5, 0);
    if_s.in_valid = 1'b1;
    tick();
    if_s.in_valid = 1'b0;
    tick();
    chk("mul_early_ov", {63'd0, if_s.out_valid}, 64'sd0);
    tick();
    chk("mul_a",     res_s(0), 64'sd2);
    chk("mul_b",     res_s(1), 64'sd20);
    chk("mul_ov",    {63'd0, if_s.out_valid}, 64'sd1);
    chk("chainout",  {44'd0, if_s.chainout}, 64'sd20);
    tick();
    chk("mul_ov_end", {63'd0, if_s.out_valid}, 64'sd0);

    // 2: pre-adder and dot product
    if_s.func = 2'b10;
    set_ops(1, 2, 3, 4, 5, 6);
    one_beat();
    chk("pre_a", res_s(0), 64'sd8);
    chk("pre_b", res_s(1), 64'sd50);
    if_s.func = 2'b11;
    one_beat();
    chk("dot_a", res_s(0), 64'sd22);
    chk("dot_b", res_s(1), 64'sd20);

    // 3: accumulate across a 2-cycle stall
    pulse_clr();
    if_s.func = 2'b00;
    if_s.accumulate = 1'b1;
    set_ops(1, 2, 0, 4, 5, 0);
    if_s.in_valid = 1'b1;
    tick();
    tick();
    if_s.enable = 1'b0;
    tick();
    chk("stall1_ov", {63'd0, if_s.out_valid}, 64'sd0);
    chk("stall1_a",  res_s(0), 64'sd0);
    tick();
    chk("stall2_ov", {63'd0, if_s.out_valid}, 64'sd0);
    if_s.enable = 1'b1;
    tick();
    if_s.in_valid = 1'b0;
    chk("acc1_a",  res_s(0), 64'sd2);
    chk("acc1_ov", {63'd0, if_s.out_valid}, 64'sd1);
    tick();
    chk("acc2_a", res_s(0), 64'sd4);
    tick();
    chk("acc3_a", res_s(0), 64'sd6);
    chk("acc3_b", res_s(1), 64'sd60);

    // 4: constant preload, negate, cascade subtract
    if_s.accumulate = 1'b0;
    if_s.loadconst = 1'b1;
    if_s.constant = {RW'(0), RW'(100)};
    set_ops(1, 2, 0, 0, 0, 0);
    one_beat();
    chk("const_a", res_s(0), 64'sd102);
    chk("const_b", res_s(1), 64'sd0);
    if_s.negate = 1'b1;
    one_beat();
    chk("const_neg_a", res_s(0), 64'sd98);
    if_s.chainin = RW'(10);
    if_s.sub = 1'b1;
    one_beat();
    chk("chain_sub_a", res_s(0), 64'sd88);
    if_s.negate = 1'b0; if_s.sub = 1'b0; if_s.loadconst = 1'b0;
    if_s.chainin = '0; if_s.constant = '0;

    // 5: 33 accumulated 127*127 beats; saturate vs wrap
    pulse_clr();
    if_s.accumulate = 1'b1;
    set_ops(127, 127, 0, 0, 0, 0);
    if_s.in_valid = 1'b1;
    tick();
    tick();
    for (int n = 1; n <= 33; n++) begin
      if (n == 32) if_s.in_valid = 1'b0;
      tick();
      if (n == 1) chk("sat_n1", res_s(0), 64'sd16129);
      if (n == 32) begin
        chk("sat_n32",     res_s(0), 64'sd516128);
        chk("sat_n32_ovf", {63'd0, if_s.ovf[0]}, 64'sd0);
        chk("wrap_n32",    res_w(0), 64'sd516128);
      end
    end
    chk("sat_n33",      res_s(0), 64'sd524287);
    chk("sat_ovf0",     {63'd0, if_s.ovf[0]}, 64'sd1);
    chk("sat_ovf1",     {63'd0, if_s.ovf[1]}, 64'sd0);
    chk("wrap_n33",     res_w(0), -64'sd516319);
    chk("wrap_ovf0",    {63'd0, if_w.ovf[0]}, 64'sd1);
    tick();
    chk("sat_ovf_sticky", {63'd0, if_s.ovf[0]}, 64'sd1);

    // 6: scan shift, then clear with two beats in flight
    if_s.accumulate = 1'b0;
    if_s.scan_en = 1'b1;
    if_s.scanin = 8'hA5;
    tick();
    if_s.scanin = 8'h3C;
    tick();
    if_s.scan_en = 1'b0;
    chk("scanout", {56'd0, if_s.scanout}, 64'sd165);
    chk("scan_ov", {63'd0, if_s.out_valid}, 64'sd0);
    set_ops(1, 2, 0, 4, 5, 0);
    if_s.in_valid = 1'b1;
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    if_s.in_valid = 1'b0;
    chk("clr_result",   {{(64-LN*RW){1'b0}}, if_s.result}, 64'sd0);
    chk("clr_ovf",      {62'd0, if_s.ovf}, 64'sd0);
    chk("clr_ov",       {63'd0, if_s.out_valid}, 64'sd0);
    chk("clr_scanout",  {56'd0, if_s.scanout}, 64'sd0);
    chk("clr_chainout", {44'd0, if_s.chainout}, 64'sd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("clr_drain_ov", {63'd0, if_s.out_valid}, 64'sd0);
    end
    chk("clr_drain_a", res_s(0), 64'sd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
